data_mem_arbiter: RTL and testbench

//  Shares the single-port 256x8 data RAM between two requesters:
//   - the ARM processor load/store port (CPU);
//   - an auxiliary master (AUX), e.g. a UART loader or display reader.

---
 rtl/data_mem_arbiter_pkg.sv | 20 ++
 rtl/data_mem_arbiter_if.sv | 49 ++++
 rtl/data_mem_arbiter_chk.sv | 23 ++
 rtl/data_mem_arbiter_starve_counter.sv | 34 +++
 rtl/data_mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and defaults for the data RAM arbiter: owner encoding, default widths,
// and the starvation counter width helper.
package dmem_arb_pkg;

    localparam int DEF_ADDR_W       = 8;
    localparam int DEF_DATA_W       = 8;
    localparam int DEF_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_AUX  = 2'd2
    } owner_t;

    // Bits needed to hold 0..limit inclusive.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bundle of the CPU, AUX and RAM-side signals around the data RAM arbiter.
// The slave modport is the arbiter's view; master is the requesters-plus-RAM side.
interface data_mem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              aux_req;
    logic              aux_we;
    logic [ADDR_W-1:0] aux_addr;
    logic [DATA_W-1:0] aux_wdata;
    logic              aux_ack;
    logic              aux_rvalid;
    logic [DATA_W-1:0] aux_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  aux_req, aux_we, aux_addr, aux_wdata,
        input  mem_rdata,
        output cpu_ack, cpu_rvalid, cpu_rdata,
        output aux_ack, aux_rvalid, aux_rdata,
        output mem_addr, mem_wdata, mem_we
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output aux_req, aux_we, aux_addr, aux_wdata,
        output mem_rdata,
        input  cpu_ack, cpu_rvalid, cpu_rdata,
        input  aux_ack, aux_rvalid, aux_rdata,
        input  mem_addr, mem_wdata, mem_we
    );

endinterface

// File: rtl/data_mem_arbiter_chk.sv
// Invariants of the arbiter: one grant per cycle and a consistent starvation counter.
module data_mem_arbiter_chk #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input logic             clk,
    input logic             rst,
    input logic             cpu_ack,
    input logic             aux_ack,
    input logic             limit_hit,
    input logic [CNT_W-1:0] starve_cnt
);

    a_single_ack : assert property (@(posedge clk) disable iff (rst)
        !(cpu_ack && aux_ack));

    a_cnt_range : assert property (@(posedge clk) disable iff (rst)
        starve_cnt <= CNT_W'(STARVE_LIMIT));

    a_limit_hit : assert property (@(posedge clk) disable iff (rst)
        limit_hit == (starve_cnt == CNT_W'(STARVE_LIMIT)));

endmodule

// File: rtl/data_mem_arbiter_starve_counter.sv
// Saturating count of consecutive cycles AUX has been refused; limit_hit forces an AUX grant.
module arb_starve_counter
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int CNT_W        = cnt_width(DEF_STARVE_LIMIT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic             limit_hit,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_r;

    // Clear wins over increment; the count never passes the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (inc && (count_r != CNT_W'(STARVE_LIMIT))) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count     = count_r;
    assign limit_hit = (count_r == CNT_W'(STARVE_LIMIT));

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares a single-port sync-read RAM between CPU and AUX: CPU-priority grant with
// starvation relief for AUX, and one-cycle read-data steering back to the owner.
module data_mem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input logic                 clk,
    input logic                 rst,
    data_mem_arbiter_if.slave   bus
);

    localparam int CNT_W = cnt_width(STARVE_LIMIT);

    logic              cpu_gnt_s;
    logic              aux_gnt_s;
    logic              limit_hit_s;
    logic [CNT_W-1:0]  starve_cnt_s;
    logic              starve_inc_s;
    logic              starve_clr_s;
    owner_t            owner_r;
    owner_t            owner_nxt_s;
    logic              rd_pend_r;
    logic              rd_pend_nxt_s;
    logic [ADDR_W-1:0] addr_hold_r;
    logic [DATA_W-1:0] wdata_hold_r;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic              mem_we_s;
    logic              cpu_rvalid_s;
    logic              aux_rvalid_s;
    logic [DATA_W-1:0] cpu_rdata_r;
    logic [DATA_W-1:0] aux_rdata_r;

    arb_starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_starve (
        .clk       (clk),
        .rst       (rst),
        .inc       (starve_inc_s),
        .clr       (starve_clr_s),
        .limit_hit (limit_hit_s),
        .count     (starve_cnt_s)
    );

    data_mem_arbiter_chk #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_chk (
        .clk        (clk),
        .rst        (rst),
        .cpu_ack    (cpu_gnt_s),
        .aux_ack    (aux_gnt_s),
        .limit_hit  (limit_hit_s),
        .starve_cnt (starve_cnt_s)
    );

    // Grant selection and owner next-state; reset blocks every grant.
    always_comb begin
        cpu_gnt_s     = 1'b0;
        aux_gnt_s     = 1'b0;
        owner_nxt_s   = OWN_NONE;
        rd_pend_nxt_s = 1'b0;
        if (rst) begin
            cpu_gnt_s = 1'b0;
        end else if (bus.aux_req && limit_hit_s) begin
            aux_gnt_s = 1'b1;
        end else if (bus.cpu_req) begin
            cpu_gnt_s = 1'b1;
        end else if (bus.aux_req) begin
            aux_gnt_s = 1'b1;
        end else begin
            aux_gnt_s = 1'b0;
        end
        if (cpu_gnt_s) begin
            owner_nxt_s   = OWN_CPU;
            rd_pend_nxt_s = ~bus.cpu_we;
        end else if (aux_gnt_s) begin
            owner_nxt_s   = OWN_AUX;
            rd_pend_nxt_s = ~bus.aux_we;
        end else begin
            owner_nxt_s   = OWN_NONE;
        end
    end

    assign starve_inc_s = bus.aux_req & ~aux_gnt_s;
    assign starve_clr_s = ~bus.aux_req | aux_gnt_s;

    // RAM-side mux; address and write data park on their last value when idle.
    always_comb begin
        mem_addr_s  = addr_hold_r;
        mem_wdata_s = wdata_hold_r;
        mem_we_s    = 1'b0;
        if (cpu_gnt_s) begin
            mem_addr_s  = bus.cpu_addr;
            mem_wdata_s = bus.cpu_wdata;
            mem_we_s    = bus.cpu_we;
        end else if (aux_gnt_s) begin
            mem_addr_s  = bus.aux_addr;
            mem_wdata_s = bus.aux_wdata;
            mem_we_s    = bus.aux_we;
        end else begin
            mem_we_s    = 1'b0;
        end
    end

    // Owner, pending-read flag and parked RAM address/data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_r      <= OWN_NONE;
            rd_pend_r    <= 1'b0;
            addr_hold_r  <= {ADDR_W{1'b0}};
            wdata_hold_r <= {DATA_W{1'b0}};
        end else begin
            owner_r      <= owner_nxt_s;
            rd_pend_r    <= rd_pend_nxt_s;
            addr_hold_r  <= mem_addr_s;
            wdata_hold_r <= mem_wdata_s;
        end
    end

    // Steer the returning read to whoever owned last cycle's access.
    always_comb begin
        cpu_rvalid_s = 1'b0;
        aux_rvalid_s = 1'b0;
        if (!rst && rd_pend_r) begin
            case (owner_r)
                OWN_CPU: cpu_rvalid_s = 1'b1;
                OWN_AUX: aux_rvalid_s = 1'b1;
                default: cpu_rvalid_s = 1'b0;
            endcase
        end else begin
            cpu_rvalid_s = 1'b0;
        end
    end

    // Capture returned data so each port's rdata holds until its next return.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rdata_r <= {DATA_W{1'b0}};
            aux_rdata_r <= {DATA_W{1'b0}};
        end else begin
            cpu_rdata_r <= cpu_rvalid_s ? bus.mem_rdata : cpu_rdata_r;
            aux_rdata_r <= aux_rvalid_s ? bus.mem_rdata : aux_rdata_r;
        end
    end

    assign bus.cpu_ack    = cpu_gnt_s;
    assign bus.aux_ack    = aux_gnt_s;
    assign bus.mem_addr   = mem_addr_s;
    assign bus.mem_wdata  = mem_wdata_s;
    assign bus.mem_we     = mem_we_s;
    assign bus.cpu_rvalid = cpu_rvalid_s;
    assign bus.aux_rvalid = aux_rvalid_s;
    assign bus.cpu_rdata  = cpu_rvalid_s ? bus.mem_rdata : cpu_rdata_r;
    assign bus.aux_rdata  = aux_rvalid_s ? bus.mem_rdata : aux_rdata_r;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus randomized traffic checked against
// a transaction-level model (priority rule, starvation count, shadow memory, return queue).
module tb_data_mem_arbiter;
    import dmem_arb_pkg::*;

    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    data_mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    data_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with one-cycle read latency
    logic [7:0] ram [256];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
        end else if (bus.mem_we) begin
            ram[bus.mem_addr] <= bus.mem_wdata;
        end
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    // Reference model state
    int         m_starve = 0;
    int         m_pend   = 0;          // 0 none, 1 cpu, 2 aux
    logic [7:0] m_pend_data = 8'h00;
    logic [7:0] m_cpu_rd = 8'h00, m_aux_rd = 8'h00;
    logic [7:0] m_last_addr = 8'h00, m_last_wdata = 8'h00;
    logic [7:0] ref_mem [256];
    logic       e_cpu_ack, e_aux_ack, e_cpu_rv, e_aux_rv, e_mem_we;
    logic [7:0] e_cpu_rdata, e_aux_rdata, e_mem_addr, e_mem_wdata;

    task automatic model_predict();
        e_cpu_ack = 1'b0;
        e_aux_ack = 1'b0;
        if (!rst) begin
            if (bus.aux_req && m_starve >= LIMIT) e_aux_ack = 1'b1;
            else if (bus.cpu_req)                 e_cpu_ack = 1'b1;
            else if (bus.aux_req)                 e_aux_ack = 1'b1;
        end
        e_cpu_rv    = !rst && (m_pend == 1);
        e_aux_rv    = !rst && (m_pend == 2);
        e_cpu_rdata = e_cpu_rv ? m_pend_data : m_cpu_rd;
        e_aux_rdata = e_aux_rv ? m_pend_data : m_aux_rd;
        e_mem_we    = (e_cpu_ack && bus.cpu_we) || (e_aux_ack && bus.aux_we);
        e_mem_addr  = e_cpu_ack ? bus.cpu_addr  : (e_aux_ack ? bus.aux_addr  : m_last_addr);
        e_mem_wdata = e_cpu_ack ? bus.cpu_wdata : (e_aux_ack ? bus.aux_wdata : m_last_wdata);
    endtask

    task automatic model_commit();
        if (rst) begin
            m_starve = 0; m_pend = 0; m_cpu_rd = 8'h00; m_aux_rd = 8'h00;
            m_last_addr = 8'h00; m_last_wdata = 8'h00;
            for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        end else begin
            if (e_cpu_rv) m_cpu_rd = m_pend_data;
            if (e_aux_rv) m_aux_rd = m_pend_data;
            m_pend = 0;
            if (e_cpu_ack || e_aux_ack) begin
                m_last_addr  = e_mem_addr;
                m_last_wdata = e_mem_wdata;
                if (e_mem_we) ref_mem[e_mem_addr] = e_mem_wdata;
                else begin
                    m_pend      = e_cpu_ack ? 1 : 2;
                    m_pend_data = ref_mem[e_mem_addr];
                end
            end
            if (!bus.aux_req || e_aux_ack) m_starve = 0;
            else if (m_starve < LIMIT)     m_starve = m_starve + 1;
        end
    endtask

    task automatic settle();
        #3;
        model_predict();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        model_commit();
    endtask

    task automatic idle_inputs();
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h00; bus.cpu_wdata = 8'h00;
        bus.aux_req = 1'b0; bus.aux_we = 1'b0; bus.aux_addr = 8'h00; bus.aux_wdata = 8'h00;
    endtask

    task automatic idle_cycle();
        idle_inputs();
        settle();
        advance();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h44; bus.cpu_wdata = 8'h99;
        bus.aux_req = 1'b1; bus.aux_we = 1'b1; bus.aux_addr = 8'h45; bus.aux_wdata = 8'h98;
        for (int c = 0; c < 2; c++) begin
            settle();
            n_checks++;
            if ({bus.cpu_ack, bus.aux_ack, bus.mem_we} !== 3'b000)
                $display("FAIL reset_acks c%0d: got ack/we=%b want 000", c, {bus.cpu_ack, bus.aux_ack, bus.mem_we});
            else n_pass++;
            if (c == 1) begin
                n_checks++;
                if ({bus.cpu_rvalid, bus.aux_rvalid, bus.cpu_rdata, bus.aux_rdata} !== 18'h0)
                    $display("FAIL reset_returns: got rv=%b%b rd=%h/%h want 0", bus.cpu_rvalid, bus.aux_rvalid, bus.cpu_rdata, bus.aux_rdata);
                else n_pass++;
            end
            advance();
        end
        rst = 1'b0;
        idle_cycle();
    endtask

    task automatic test_cpu_only();
        idle_inputs();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h10; bus.cpu_wdata = 8'h5A;
        settle();
        n_checks++;
        if ({bus.cpu_ack, bus.aux_ack, bus.mem_we, bus.mem_addr} !== {3'b101, 8'h10})
            $display("FAIL cpu_write_issue: got ack=%b we=%b addr=%h want ack=1 we=1 addr=10", bus.cpu_ack, bus.mem_we, bus.mem_addr);
        else n_pass++;
        advance();
        bus.cpu_we = 1'b0;
        settle();
        n_checks++;
        if ({bus.cpu_ack, bus.mem_we} !== 2'b10)
            $display("FAIL cpu_read_issue: got ack=%b we=%b want ack=1 we=0", bus.cpu_ack, bus.mem_we);
        else n_pass++;
        advance();
        idle_inputs();
        settle();
        n_checks++;
        if ({bus.cpu_rvalid, bus.aux_rvalid, bus.cpu_rdata} !== {2'b10, 8'h5A})
            $display("FAIL cpu_read_return: got rv=%b aux_rv=%b rdata=%h want 1 0 5a", bus.cpu_rvalid, bus.aux_rvalid, bus.cpu_rdata);
        else n_pass++;
        advance();
    endtask

    task automatic test_contention();
        idle_cycle();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h11;
        bus.aux_req = 1'b1; bus.aux_we = 1'b0; bus.aux_addr = 8'h20;
        for (int k = 0; k < 10; k++) begin
            logic x_aux_ack, x_aux_rv, x_cpu_rv;
            x_aux_ack = (k % 5 == 4);
            x_aux_rv  = (k % 5 == 0) && (k != 0);
            x_cpu_rv  = (k != 0) && !x_aux_rv;
            settle();
            n_checks++;
            if ({bus.cpu_ack, bus.aux_ack, bus.cpu_rvalid, bus.aux_rvalid} !== {!x_aux_ack, x_aux_ack, x_cpu_rv, x_aux_rv})
                $display("FAIL contention k%0d: got ack=%b%b rv=%b%b want %b%b %b%b", k, bus.cpu_ack, bus.aux_ack,
                         bus.cpu_rvalid, bus.aux_rvalid, !x_aux_ack, x_aux_ack, x_cpu_rv, x_aux_rv);
            else n_pass++;
            if (x_aux_rv) begin
                n_checks++;
                if (bus.aux_rdata !== e_aux_rdata)
                    $display("FAIL contention_aux_data k%0d: got %h want %h", k, bus.aux_rdata, e_aux_rdata);
                else n_pass++;
            end
            advance();
        end
    endtask

    task automatic test_aux_burst();
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'(k); bus.cpu_wdata = 8'hC0 + 8'(k);
            settle();
            advance();
        end
        idle_cycle();
        for (int k = 0; k < 5; k++) begin
            idle_inputs();
            bus.aux_req  = (k < 4);
            bus.aux_addr = 8'(k);
            settle();
            n_checks++;
            if ({bus.aux_ack, bus.aux_rvalid, bus.cpu_rvalid} !== {(k < 4), (k >= 1), 1'b0})
                $display("FAIL aux_burst k%0d: got ack=%b rv=%b cpu_rv=%b want %b %b 0", k, bus.aux_ack,
                         bus.aux_rvalid, bus.cpu_rvalid, (k < 4), (k >= 1));
            else n_pass++;
            if (k >= 1) begin
                n_checks++;
                if (bus.aux_rdata !== 8'hC0 + 8'(k - 1))
                    $display("FAIL aux_burst_data k%0d: got %h want %h", k, bus.aux_rdata, 8'hC0 + 8'(k - 1));
                else n_pass++;
            end
            advance();
        end
    endtask

    task automatic test_race();
        idle_cycle();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h30; bus.cpu_wdata = 8'hA5;
        bus.aux_req = 1'b1; bus.aux_we = 1'b0; bus.aux_addr = 8'h30;
        settle();
        n_checks++;
        if ({bus.cpu_ack, bus.aux_ack} !== 2'b10)
            $display("FAIL race_first: got ack=%b%b want 10", bus.cpu_ack, bus.aux_ack);
        else n_pass++;
        advance();
        bus.cpu_req = 1'b0;
        settle();
        n_checks++;
        if ({bus.cpu_ack, bus.aux_ack} !== 2'b01)
            $display("FAIL race_second: got ack=%b%b want 01", bus.cpu_ack, bus.aux_ack);
        else n_pass++;
        advance();
        idle_inputs();
        settle();
        n_checks++;
        if ({bus.aux_rvalid, bus.aux_rdata} !== {1'b1, 8'hA5})
            $display("FAIL race_return: got rv=%b rdata=%h want 1 a5", bus.aux_rvalid, bus.aux_rdata);
        else n_pass++;
        advance();
    endtask

    task automatic test_reset_mid_read();
        idle_cycle();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h10;
        settle();
        n_checks++;
        if (bus.cpu_ack !== 1'b1)
            $display("FAIL rst_mid_ack: got %b want 1", bus.cpu_ack);
        else n_pass++;
        advance();
        idle_inputs();
        rst = 1'b1;
        settle();
        n_checks++;
        if (bus.cpu_rvalid !== 1'b0)
            $display("FAIL rst_mid_rvalid: got %b want 0", bus.cpu_rvalid);
        else n_pass++;
        advance();
        rst = 1'b0;
        settle();
        n_checks++;
        if ({bus.cpu_rvalid, bus.aux_rvalid} !== 2'b00 || dut.owner_r !== OWN_NONE)
            $display("FAIL rst_mid_after: got rv=%b%b owner=%0d want 00 owner=0", bus.cpu_rvalid, bus.aux_rvalid, dut.owner_r);
        else n_pass++;
        advance();
    endtask

    task automatic test_random();
        idle_inputs();
        e_cpu_ack = 1'b0;
        e_aux_ack = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!bus.cpu_req || e_cpu_ack) begin
                bus.cpu_req = ($urandom_range(0, 3) != 0); bus.cpu_we = 1'($urandom_range(0, 1));
                bus.cpu_addr = 8'($urandom_range(0, 15)); bus.cpu_wdata = 8'($urandom);
            end else if ($urandom_range(0, 7) == 0) bus.cpu_req = 1'b0;
            if (!bus.aux_req || e_aux_ack) begin
                bus.aux_req = ($urandom_range(0, 3) != 0); bus.aux_we = 1'($urandom_range(0, 1));
                bus.aux_addr = 8'($urandom_range(0, 15)); bus.aux_wdata = 8'($urandom);
            end else if ($urandom_range(0, 7) == 0) bus.aux_req = 1'b0;
            settle();
            n_checks++;
            if ({bus.cpu_ack, bus.aux_ack, bus.mem_we, bus.cpu_rvalid, bus.aux_rvalid} !==
                {e_cpu_ack, e_aux_ack, e_mem_we, e_cpu_rv, e_aux_rv})
                $display("FAIL rand_ctl c%0d: got ack=%b%b we=%b rv=%b%b want ack=%b%b we=%b rv=%b%b", c,
                         bus.cpu_ack, bus.aux_ack, bus.mem_we, bus.cpu_rvalid, bus.aux_rvalid,
                         e_cpu_ack, e_aux_ack, e_mem_we, e_cpu_rv, e_aux_rv);
            else n_pass++;
            n_checks++;
            if ({bus.mem_addr, bus.mem_wdata, bus.cpu_rdata, bus.aux_rdata} !== {e_mem_addr, e_mem_wdata, e_cpu_rdata, e_aux_rdata})
                $display("FAIL rand_data c%0d: got addr=%h wd=%h rd=%h/%h want addr=%h wd=%h rd=%h/%h", c,
                         bus.mem_addr, bus.mem_wdata, bus.cpu_rdata, bus.aux_rdata,
                         e_mem_addr, e_mem_wdata, e_cpu_rdata, e_aux_rdata);
            else n_pass++;
            advance();
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_cpu_only();
        test_contention();
        test_aux_burst();
        test_race();
        test_reset_mid_read();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
